// File: rtl/ppu_pkg.sv
// Shared PPU definitions: buffer geometry, sprite fetch state encoding and
// the packed 4-byte sprite record handed to the pattern fetcher.
package ppu_pkg;

  localparam int OAMB_DEPTH       = 32;
  localparam int BYTES_PER_SPRITE = 4;
  localparam int MAX_SPRITES      = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LAST,
    PRESENT,
    FINISH
  } fetch_state_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] x;
  } sprite_rec_t;

  // Byte address of byte b within sprite slot s in the secondary OAM buffer.
  function automatic logic [$clog2(OAMB_DEPTH)-1:0] sprite_byte_addr(
    input logic [2:0] s,
    input logic [1:0] b
  );
    return {s, b};
  endfunction

endpackage

// File: rtl/ppu_sprite_fetch.sv
// Per-line sprite record fetcher: reads 4 bytes per slot from the secondary OAM
// buffer and presents each record with a valid/ready handshake.
// Optional macro PPU_SPRFETCH_SKIP_EMPTY_EN: slots whose Y byte is 0xFF are skipped.
module ppu_sprite_fetch
  import ppu_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int OAMB_AW     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [3:0]         sprite_count,
  output logic [OAMB_AW-1:0] oamb_addr,
  input  logic [7:0]         oamb_rdata,
  output logic [7:0]         spr_y,
  output logic [7:0]         spr_tile,
  output logic [7:0]         spr_attr,
  output logic [7:0]         spr_x,
  output logic [2:0]         spr_idx,
  output logic               spr_valid,
  input  logic               spr_ready,
  output logic               busy,
  output logic               done
);

  localparam int SLOT_LIMIT = (NUM_SPRITES < MAX_SPRITES) ? NUM_SPRITES : MAX_SPRITES;

  fetch_state_t state;
  sprite_rec_t  spr_rec;
  logic [3:0]   slot;
  logic [3:0]   count;
  logic [1:0]   byte_sel;
  logic         pend_valid;
  logic [1:0]   pend_sel;
  logic [7:0]   cap_y;
  logic [7:0]   cap_tile;
  logic [7:0]   cap_attr;
  logic [3:0]   count_clamped;
  logic [3:0]   slot_next;
  logic         skip_slot;

  assign count_clamped = (sprite_count > 4'(SLOT_LIMIT)) ? 4'(SLOT_LIMIT) : sprite_count;
  assign slot_next     = slot + 4'd1;

`ifdef PPU_SPRFETCH_SKIP_EMPTY_EN
  assign skip_slot = (cap_y == 8'hFF);
`else
  assign skip_slot = 1'b0;
`endif

  assign spr_y    = spr_rec.y;
  assign spr_tile = spr_rec.tile;
  assign spr_attr = spr_rec.attr;
  assign spr_x    = spr_rec.x;

  // Read data trails the address by one cycle, so the byte select is delayed
  // alongside it; byte 3 goes straight from the bus into the presented record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      slot       <= '0;
      count      <= '0;
      byte_sel   <= '0;
      pend_valid <= 1'b0;
      pend_sel   <= '0;
      cap_y      <= '0;
      cap_tile   <= '0;
      cap_attr   <= '0;
      spr_rec    <= '0;
      spr_idx    <= '0;
      spr_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      oamb_addr  <= '0;
    end else begin
      pend_valid <= (state == ADDR);
      pend_sel   <= byte_sel;
      if (pend_valid) begin
        case (pend_sel)
          2'd0:    cap_y    <= oamb_rdata;
          2'd1:    cap_tile <= oamb_rdata;
          2'd2:    cap_attr <= oamb_rdata;
          default: ;
        endcase
      end

      if (abort && state != IDLE) begin
        state     <= IDLE;
        spr_valid <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
        oamb_addr <= '0;
      end else begin
        case (state)
          IDLE: begin
            done <= 1'b0;
            if (start) begin
              count    <= count_clamped;
              slot     <= '0;
              byte_sel <= '0;
              busy     <= 1'b1;
              if (count_clamped == 4'd0) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                state     <= ADDR;
                oamb_addr <= OAMB_AW'(sprite_byte_addr(3'd0, 2'd0));
              end
            end
          end

          ADDR: begin
            if (byte_sel == 2'(BYTES_PER_SPRITE - 1)) begin
              state     <= LAST;
              oamb_addr <= '0;
            end else begin
              byte_sel  <= byte_sel + 2'd1;
              oamb_addr <= OAMB_AW'(sprite_byte_addr(slot[2:0], byte_sel + 2'd1));
            end
          end

          LAST: begin
            if (skip_slot) begin
              if (slot_next >= count) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                slot      <= slot_next;
                byte_sel  <= '0;
                state     <= ADDR;
                oamb_addr <= OAMB_AW'(sprite_byte_addr(slot_next[2:0], 2'd0));
              end
            end else begin
              spr_rec   <= '{y: cap_y, tile: cap_tile, attr: cap_attr, x: oamb_rdata};
              spr_idx   <= slot[2:0];
              spr_valid <= 1'b1;
              state     <= PRESENT;
            end
          end

          PRESENT: begin
            if (spr_ready) begin
              spr_valid <= 1'b0;
              if (slot_next >= count) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                slot      <= slot_next;
                byte_sel  <= '0;
                state     <= ADDR;
                oamb_addr <= OAMB_AW'(sprite_byte_addr(slot_next[2:0], 2'd0));
              end
            end
          end

          FINISH: begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
